rv32i_io_top: RTL and testbench

- Memory-mapped IO responder at the far end of the pipeline's IO interface. It decodes word addresses with io_addr[31]=1 and services byte-enabled writes.
- Returns io_rdata with one-cycle registered latency, matching the synchronous data RAM.
- Holds an LED register, a synchronized switch input, a free-running cycle counter and a compare timer with an interrupt flag.

---
 rtl/rv32i_io_pkg.sv | 36 +++
 rtl/rv32i_io_timer.sv | 100 ++++++++++
 rtl/rv32i_io_top.sv | 109 ++++++++++
 tb/tb_rv32i_io_top.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_io_pkg.sv
// Shared constants, timer state encoding and byte-lane helper for the IO block.
package rv32i_io_pkg;

  // Word offsets, taken from io_addr[4:2]
  localparam logic [2:0] IO_LED   = 3'd0;
  localparam logic [2:0] IO_SW    = 3'd1;
  localparam logic [2:0] IO_CYCLE = 3'd2;
  localparam logic [2:0] IO_CMP   = 3'd3;
  localparam logic [2:0] IO_CTRL  = 3'd4;
  localparam logic [2:0] IO_CNT   = 3'd5;

  // CTRL register bit positions
  localparam int EN_BIT     = 0;
  localparam int RELOAD_BIT = 1;
  localparam int MATCH_BIT  = 8;

  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // Replace only the byte lanes whose enable is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32i_io_timer.sv
// Compare timer: CNT/CMP/CTRL registers plus the IDLE/RUN/DONE sequencer.
//
//   state | meaning
//   IDLE  | EN clear, CNT holds
//   RUN   | counting up, compares CNT against CMP each cycle
//   DONE  | one-shot match reached, CNT holds until CNT/CMP rewritten
module rv32i_io_timer
  import rv32i_io_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic        ctrl_we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic [31:0] ctrl_o,
  output logic        irq_o
);

  timer_state_t state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  cmp_q, cmp_d;
  logic         en_q, en_d;
  logic         reload_q, reload_d;
  logic         match_q, match_d;
  logic         match_set;

  // State and register update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmp_q    <= CMP_RST;
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      reload_q <= reload_d;
      match_q  <= match_d;
    end
  end

  // Next-state: hardware counting first, then software writes override
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmp_d     = cmp_q;
    en_d      = en_q;
    reload_d  = reload_q;
    match_d   = match_q;
    match_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_q) state_d = RUN;
      end
      RUN: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (cnt_q == cmp_q) begin
          match_set = 1'b1;
          if (reload_q) cnt_d = '0;
          else          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        if (!en_q)                     state_d = IDLE;
        else if (cnt_we_i || cmp_we_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    if (cnt_we_i) cnt_d = be_merge(cnt_q, wdata_i, be_i);
    if (cmp_we_i) cmp_d = be_merge(cmp_q, wdata_i, be_i);
    if (ctrl_we_i && be_i[0]) begin
      en_d     = wdata_i[EN_BIT];
      reload_d = wdata_i[RELOAD_BIT];
    end
    // A hardware match in the same cycle as a W1C keeps the flag set
    if (match_set)
      match_d = 1'b1;
    else if (ctrl_we_i && be_i[1] && wdata_i[MATCH_BIT])
      match_d = 1'b0;
  end

  assign cnt_o  = cnt_q;
  assign cmp_o  = cmp_q;
  assign ctrl_o = {23'd0, match_q, 6'd0, reload_q, en_q};
  assign irq_o  = match_q;

endmodule

// File: rtl/rv32i_io_top.sv
// Memory-mapped IO responder: decode, LED, switch sync, cycle counter, read register.
module rv32i_io_top
  import rv32i_io_pkg::*;
#(
  parameter int LED_WIDTH   = 16,
  parameter int SW_WIDTH    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_we,
  input  logic [3:0]           io_be,
  input  logic [31:2]          io_addr,
  input  logic [31:0]          io_wdata,
  output logic [31:0]          io_rdata,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 timer_irq
);

  logic                 sel;
  logic [2:0]           off;
  logic                 wr;
  logic                 led_we, cnt_we, cmp_we, ctrl_we;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [31:0]          cycle_q;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          cnt_v, cmp_v, ctrl_v;
  logic                 unused_addr;

  // Upper offset bits alias onto the same registers
  assign unused_addr = ^io_addr[30:5];

  assign sel     = io_addr[31];
  assign off     = io_addr[4:2];
  assign wr      = io_we && sel;
  assign led_we  = wr && (off == IO_LED);
  assign cmp_we  = wr && (off == IO_CMP);
  assign ctrl_we = wr && (off == IO_CTRL);
  assign cnt_we  = wr && (off == IO_CNT);

  rv32i_io_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .cnt_we_i  (cnt_we),
    .cmp_we_i  (cmp_we),
    .ctrl_we_i (ctrl_we),
    .be_i      (io_be),
    .wdata_i   (io_wdata),
    .cnt_o     (cnt_v),
    .cmp_o     (cmp_v),
    .ctrl_o    (ctrl_v),
    .irq_o     (timer_irq)
  );

  // Byte-enabled LED next value
  always_comb begin
    led_d = led_q;
    if (led_we) led_d = LED_WIDTH'(be_merge(32'(led_q), io_wdata, io_be));
  end

  // LED register and free-running cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q   <= '0;
      cycle_q <= '0;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Switch synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Read mux on the current address, pre-edge register values
  always_comb begin
    rdata_d = '0;
    if (sel) begin
      unique case (off)
        IO_LED:   rdata_d = 32'(led_q);
        IO_SW:    rdata_d = 32'(sync_q[SYNC_STAGES-1]);
        IO_CYCLE: rdata_d = cycle_q;
        IO_CMP:   rdata_d = cmp_v;
        IO_CTRL:  rdata_d = ctrl_v;
        IO_CNT:   rdata_d = cnt_v;
        default:  rdata_d = '0;
      endcase
    end
  end

  // One-cycle registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign io_rdata = rdata_q;
  assign led_out  = led_q;

endmodule

// File: tb/tb_rv32i_io_top.sv
// Directed bench for rv32i_io_top: vector table plus timer/sync/reset sequences.
module tb_rv32i_io_top;

  localparam logic [31:0] A_LED   = 32'h8000_0000;
  localparam logic [31:0] A_SW    = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE = 32'h8000_0008;
  localparam logic [31:0] A_CMP   = 32'h8000_000C;
  localparam logic [31:0] A_CTRL  = 32'h8000_0010;
  localparam logic [31:0] A_CNT   = 32'h8000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_we;
  logic [3:0]  io_be;
  logic [31:2] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        timer_irq;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  rv32i_io_top dut (
    .clk       (clk),
    .reset     (reset),
    .io_we     (io_we),
    .io_be     (io_be),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    io_we    = 1'b1;
    io_be    = be;
    io_addr  = a[31:2];
    io_wdata = d;
    cyc();
    io_we    = 1'b0;
  endtask

  function automatic vec_t wv(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    vec_t v;
    v.we = 1'b1; v.be = be; v.addr = a; v.wdata = d; v.chk = 1'b0; v.exp = '0;
    return v;
  endfunction

  function automatic vec_t rv(input logic [31:0] a, input logic [31:0] e);
    vec_t v;
    v.we = 1'b0; v.be = 4'h0; v.addr = a; v.wdata = '0; v.chk = 1'b1; v.exp = e;
    return v;
  endfunction

  initial begin
    int n;
    logic [31:0] seq_exp [7];

    // reset values, then static register behaviour
    vecs.push_back(rv(A_LED,  32'h0));
    vecs.push_back(rv(A_CMP,  32'hFFFF_FFFF));
    vecs.push_back(rv(A_CNT,  32'h0));
    vecs.push_back(rv(A_CTRL, 32'h0));
    vecs.push_back(rv(A_SW,   32'h0));
    vecs.push_back(wv(A_LED, 4'hF, 32'h0000_1234));
    vecs.push_back(rv(A_LED,  32'h0000_1234));
    vecs.push_back(wv(A_LED, 4'b0010, 32'h0000_AB00));
    vecs.push_back(rv(A_LED,  32'h0000_AB34));
    vecs.push_back(wv(A_LED, 4'b1100, 32'hFFFF_0000));
    vecs.push_back(rv(A_LED,  32'h0000_AB34));
    vecs.push_back(rv(32'h0000_0000, 32'h0));
    vecs.push_back(wv(32'h0000_0000, 4'hF, 32'hFFFF_FFFF));
    vecs.push_back(rv(A_LED,  32'h0000_AB34));
    vecs.push_back(wv(A_CMP, 4'hF, 32'hDEAD_BEEF));
    vecs.push_back(rv(A_CMP,  32'hDEAD_BEEF));
    vecs.push_back(wv(A_CMP, 4'b0001, 32'h0000_0011));
    vecs.push_back(rv(A_CMP,  32'hDEAD_BE11));
    vecs.push_back(rv(32'h8000_0018, 32'h0));
    vecs.push_back(wv(32'h8000_001C, 4'hF, 32'h1234_5678));
    vecs.push_back(rv(32'h8000_001C, 32'h0));
    vecs.push_back(rv(32'h8000_0100, 32'h0000_AB34));
    vecs.push_back(wv(A_CTRL, 4'hF, 32'h0000_0002));
    vecs.push_back(rv(A_CTRL, 32'h0000_0002));
    vecs.push_back(wv(A_CTRL, 4'hF, 32'hFFFF_FEF0));
    vecs.push_back(rv(A_CTRL, 32'h0));
    vecs.push_back(wv(A_CNT, 4'hF, 32'h0000_0055));
    vecs.push_back(rv(A_CNT,  32'h0000_0055));
    vecs.push_back(rv(A_CNT,  32'h0000_0055));

    reset = 1'b1; io_we = 1'b0; io_be = 4'h0; io_addr = '0; io_wdata = '0; sw_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk32("led_out_rst", 32'(led_out), 32'h0);
    chk32("irq_rst", 32'(timer_irq), 32'h0);

    foreach (vecs[i]) begin
      io_we    = vecs[i].we;
      io_be    = vecs[i].be;
      io_addr  = vecs[i].addr[31:2];
      io_wdata = vecs[i].wdata;
      cyc();
      if (vecs[i].chk) chk32($sformatf("vec%0d", i), io_rdata, vecs[i].exp);
    end
    io_we = 1'b0;
    chk32("led_out", 32'(led_out), 32'h0000_AB34);

    // switch synchronizer latency
    io_addr = A_SW[31:2];
    sw_in   = 16'h5A5A;
    cyc();
    cyc();
    chk32("sw_t1", io_rdata, 32'h0);
    cyc();
    chk32("sw_t2", io_rdata, 32'h0000_5A5A);

    // one-shot timer
    wr(A_CMP, 4'hF, 32'd5);
    wr(A_CNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h1);
    io_addr = A_CNT[31:2];
    n = 0;
    while (n < 20 && !timer_irq) begin cyc(); n++; end
    chk32("oneshot_edges", 32'(n), 32'd7);
    chk32("oneshot_cnt", io_rdata, 32'd5);
    cyc();
    chk32("oneshot_hold", io_rdata, 32'd5);
    wr(A_CTRL, 4'b0011, 32'h0000_0101);
    chk32("oneshot_w1c", 32'(timer_irq), 32'h0);
    wr(A_CTRL, 4'hF, 32'h0);

    // auto-reload
    wr(A_CNT, 4'hF, 32'd0);
    wr(A_CMP, 4'hF, 32'd3);
    wr(A_CTRL, 4'hF, 32'h3);
    io_addr = A_CNT[31:2];
    seq_exp = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk32($sformatf("reload_cnt%0d", k), io_rdata, seq_exp[k]);
      if (k == 3) chk32("reload_irq_pre", 32'(timer_irq), 32'h0);
      if (k == 4) chk32("reload_irq", 32'(timer_irq), 32'h1);
    end
    wr(A_CTRL, 4'b0011, 32'h0000_0103);
    chk32("w1c_clear", 32'(timer_irq), 32'h0);
    wr(A_CTRL, 4'b0011, 32'h0000_0103);
    chk32("w1c_vs_set", 32'(timer_irq), 32'h1);
    wr(A_CTRL, 4'hF, 32'h0);

    // counter wrap then match at 0x10
    wr(A_CMP, 4'hF, 32'h10);
    wr(A_CNT, 4'hF, 32'hFFFF_FFFF);
    wr(A_CTRL, 4'b0011, 32'h0000_0101);
    io_addr = A_CNT[31:2];
    cyc();
    cyc();
    chk32("wrap_pre", io_rdata, 32'hFFFF_FFFF);
    cyc();
    chk32("wrap_zero", io_rdata, 32'h0);
    n = 3;
    while (n < 40 && !timer_irq) begin cyc(); n++; end
    chk32("wrap_edges", 32'(n), 32'd19);
    chk32("wrap_match_cnt", io_rdata, 32'h10);

    // async reset mid-run with MATCH set
    wr(A_LED, 4'hF, 32'h0000_00C3);
    wr(A_CMP, 4'hF, 32'd2);
    wr(A_CNT, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h3);
    io_addr = A_CNT[31:2];
    n = 0;
    while (n < 20 && !timer_irq) begin cyc(); n++; end
    chk32("prerst_irq", 32'(timer_irq), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk32("rst_led", 32'(led_out), 32'h0);
    chk32("rst_irq", 32'(timer_irq), 32'h0);
    chk32("rst_rdata", io_rdata, 32'h0);
    io_addr = A_CYCLE[31:2];
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk32($sformatf("cycle%0d", k), io_rdata, 32'(k - 1));
    end
    io_addr = A_CMP[31:2];
    cyc();
    chk32("post_rst_cmp", io_rdata, 32'hFFFF_FFFF);
    io_addr = A_CTRL[31:2];
    cyc();
    chk32("post_rst_ctrl", io_rdata, 32'h0);
    io_addr = A_CNT[31:2];
    cyc();
    cyc();
    chk32("post_rst_cnt", io_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
